// File: rtl/entity_mover.sv
// entity_mover: position/direction store for N_ENT entities with wall-checked moves.
// Latency: 2 cycles from accept to rsp_valid for error/edge, 2+RAM_LAT when the board RAM is read.
// Backpressure: one request in flight; req_ready is high only in IDLE, requester holds otherwise.
module entity_mover #(
  parameter int COL_BITS = 4,
  parameter int ROW_BITS = 4,
  parameter int N_ENT    = 4,
  parameter int RAM_LAT  = 1,
  localparam int POS_W   = ROW_BITS + COL_BITS,
  localparam int ID_W    = (N_ENT > 1) ? $clog2(N_ENT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ID_W-1:0]  req_id,
  input  logic [7:0]       req_dir,
  output logic             wall_ren,
  output logic [POS_W-1:0] wall_addr,
  input  logic [7:0]       wall_rdata,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic [POS_W-1:0] rsp_pos,
  output logic [7:0]       rsp_dir,
  output logic             rsp_blocked,
  output logic             rsp_err,
  input  logic [ID_W-1:0]  rd_id,
  output logic [POS_W-1:0] rd_pos,
  output logic [7:0]       rd_dir
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [ID_W:0] N_ENT_L = (ID_W+1)'(N_ENT);

  typedef enum logic [1:0] {IDLE, CALC, WAIT, COMMIT} state_t;

  state_t state, next_state;

  logic [POS_W-1:0] pos_q [N_ENT];
  logic [7:0]       dir_q [N_ENT];

  logic [ID_W-1:0]  lat_id;
  logic [7:0]       lat_dir;
  logic [POS_W-1:0] cand;
  logic             blocked;
  logic             err;
  logic [CNT_W-1:0] cnt;

  logic             id_ok;
  logic             dir_ok;
  logic             at_edge;
  logic [POS_W-1:0] cur_pos;
  logic [7:0]       cur_dir;
  logic [POS_W-1:0] cand_c;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;

  // Current state of the latched entity and the candidate cell for the latched direction.
  always_comb begin
    cur_pos = '0;
    cur_dir = '0;
    id_ok   = ({1'b0, lat_id} < N_ENT_L);
    if (id_ok) begin
      cur_pos = pos_q[lat_id];
      cur_dir = dir_q[lat_id];
    end
    row     = cur_pos[POS_W-1:COL_BITS];
    col     = cur_pos[COL_BITS-1:0];
    dir_ok  = 1'b1;
    at_edge = 1'b0;
    cand_c  = cur_pos;
    case (lat_dir)
      8'h00: begin at_edge = (row == '0); if (!at_edge) cand_c = {row - ROW_BITS'(1), col}; end
      8'h01: begin at_edge = (row == '1); if (!at_edge) cand_c = {row + ROW_BITS'(1), col}; end
      8'h03: begin at_edge = (col == '0); if (!at_edge) cand_c = {row, col - COL_BITS'(1)}; end
      8'h07: begin at_edge = (col == '1); if (!at_edge) cand_c = {row, col + COL_BITS'(1)}; end
      default: dir_ok = 1'b0;
    endcase
  end

  // State register; reset aborts anything in flight.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake/response outputs.
  always_comb begin
    next_state  = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_pos     = '0;
    rsp_dir     = '0;
    rsp_blocked = 1'b0;
    rsp_err     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next_state = CALC;
      end
      CALC: begin
        if (!id_ok || !dir_ok || at_edge) next_state = COMMIT;
        else                              next_state = WAIT;
      end
      WAIT: begin
        if (cnt == '0) next_state = COMMIT;
      end
      COMMIT: begin
        next_state  = IDLE;
        rsp_valid   = 1'b1;
        rsp_id      = lat_id;
        rsp_pos     = (err || blocked) ? cur_pos : cand;
        rsp_dir     = err ? cur_dir : lat_dir;
        rsp_blocked = blocked;
        rsp_err     = err;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, wall lookup, entity state update and readback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_ENT; i++) begin
        pos_q[i] <= (i % 2 == 1) ? '1 : '0;
        dir_q[i] <= (i % 2 == 1) ? 8'h00 : 8'h01;
      end
      lat_id    <= '0;
      lat_dir   <= '0;
      cand      <= '0;
      blocked   <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
      wall_ren  <= 1'b0;
      wall_addr <= '0;
      rd_pos    <= '0;
      rd_dir    <= '0;
    end else begin
      wall_ren <= 1'b0;
      if ({1'b0, rd_id} < N_ENT_L) begin
        rd_pos <= pos_q[rd_id];
        rd_dir <= dir_q[rd_id];
      end else begin
        rd_pos <= '0;
        rd_dir <= '0;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_id  <= req_id;
            lat_dir <= req_dir;
            blocked <= 1'b0;
            err     <= 1'b0;
          end
        end
        CALC: begin
          cand <= cand_c;
          if (!id_ok || !dir_ok) begin
            err <= 1'b1;
          end else if (at_edge) begin
            blocked <= 1'b1;
          end else begin
            wall_ren  <= 1'b1;
            wall_addr <= cand_c;
            cnt       <= CNT_W'(RAM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) blocked <= (wall_rdata != 8'h00);
          else           cnt     <= cnt - CNT_W'(1);
        end
        COMMIT: begin
          if (!err) begin
            dir_q[lat_id] <= lat_dir;
            if (!blocked) pos_q[lat_id] <= cand;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_entity_mover.sv
// Directed table-driven bench for entity_mover (RAM_LAT=1 and RAM_LAT=3 instances).
// Each request is traced cycle by cycle from its accept edge to the response strobe.
// Covers edges, walls, illegal directions, back-to-back requests and reset mid-lookup.
module tb_entity_mover;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_valid3;
  logic [1:0] req_id;
  logic [7:0] req_dir;
  logic [7:0] wall_rdata;
  logic [1:0] rd_id;

  logic       req_ready, wall_ren, rsp_valid, rsp_blocked, rsp_err;
  logic [7:0] wall_addr, rsp_pos, rsp_dir, rd_pos, rd_dir;
  logic [1:0] rsp_id;
  logic       req_ready3, wall_ren3, rsp_valid3, rsp_blocked3, rsp_err3;
  logic [7:0] wall_addr3, rsp_pos3, rsp_dir3, rd_pos3, rd_dir3;
  logic [1:0] rsp_id3;

  int n_chk = 0;
  int n_err = 0;
  bit sel = 1'b0;

  always #5 clk = ~clk;

  entity_mover #(.RAM_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_dir(req_dir), .wall_ren(wall_ren), .wall_addr(wall_addr),
    .wall_rdata(wall_rdata), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_pos(rsp_pos),
    .rsp_dir(rsp_dir), .rsp_blocked(rsp_blocked), .rsp_err(rsp_err),
    .rd_id(rd_id), .rd_pos(rd_pos), .rd_dir(rd_dir));

  entity_mover #(.RAM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_id(req_id), .req_dir(req_dir), .wall_ren(wall_ren3), .wall_addr(wall_addr3),
    .wall_rdata(wall_rdata), .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_pos(rsp_pos3),
    .rsp_dir(rsp_dir3), .rsp_blocked(rsp_blocked3), .rsp_err(rsp_err3),
    .rd_id(rd_id), .rd_pos(rd_pos3), .rd_dir(rd_dir3));

  // Observation mux: sel picks which instance the tasks look at.
  logic       m_ready, m_ren, m_rv, m_blk, m_err;
  logic [7:0] m_addr, m_pos, m_dir, m_rdpos, m_rddir;
  logic [1:0] m_id;
  assign m_ready = sel ? req_ready3   : req_ready;
  assign m_ren   = sel ? wall_ren3    : wall_ren;
  assign m_rv    = sel ? rsp_valid3   : rsp_valid;
  assign m_blk   = sel ? rsp_blocked3 : rsp_blocked;
  assign m_err   = sel ? rsp_err3     : rsp_err;
  assign m_addr  = sel ? wall_addr3   : wall_addr;
  assign m_pos   = sel ? rsp_pos3     : rsp_pos;
  assign m_dir   = sel ? rsp_dir3     : rsp_dir;
  assign m_id    = sel ? rsp_id3      : rsp_id;
  assign m_rdpos = sel ? rd_pos3      : rd_pos;
  assign m_rddir = sel ? rd_dir3      : rd_dir;

  typedef struct {
    logic [1:0] id;
    logic [7:0] dir;
    logic [7:0] rdata;
    int         lat;
    int         ren_cyc;
    logic [7:0] addr;
    logic [7:0] pos;
    logic [7:0] dir_o;
    logic       blk;
    logic       err;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int got_lat = 0, ren_cyc = 0, ren_cnt = 0;
    logic [7:0] addr = 8'h00, pos = 8'h00, dir = 8'h00;
    logic [1:0] id = 2'd0;
    logic blk = 1'b0, err = 1'b0;
    @(negedge clk);
    req_id = v.id; req_dir = v.dir; wall_rdata = v.rdata;
    if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_valid3 = 1'b0;
    for (int k = 1; k <= 10 && got_lat == 0; k++) begin
      @(negedge clk);
      if (m_ren) begin
        ren_cnt++;
        if (ren_cyc == 0) ren_cyc = k;
        addr = m_addr;
      end
      if (m_rv) begin
        got_lat = k; pos = m_pos; dir = m_dir; id = m_id; blk = m_blk; err = m_err;
      end
    end
    @(negedge clk);
    chk({tag, " rsp_one_cycle"}, {31'd0, m_rv}, 32'd0);
    chk({tag, " ready_after"}, {31'd0, m_ready}, 32'd1);
    chk({tag, " latency"}, got_lat, v.lat);
    chk({tag, " ren_cycle"}, ren_cyc, v.ren_cyc);
    chk({tag, " ren_count"}, ren_cnt, (v.ren_cyc != 0) ? 1 : 0);
    chk({tag, " addr"}, {24'd0, addr}, {24'd0, v.addr});
    chk({tag, " rsp_id"}, {30'd0, id}, {30'd0, v.id});
    chk({tag, " rsp_pos"}, {24'd0, pos}, {24'd0, v.pos});
    chk({tag, " rsp_dir"}, {24'd0, dir}, {24'd0, v.dir_o});
    chk({tag, " blocked"}, {31'd0, blk}, {31'd0, v.blk});
    chk({tag, " err"}, {31'd0, err}, {31'd0, v.err});
  endtask

  task automatic readback(input logic [1:0] id, input logic [7:0] ep, input logic [7:0] ed, input string tag);
    @(negedge clk);
    rd_id = id;
    @(negedge clk);
    chk({tag, " rd_pos"}, {24'd0, m_rdpos}, {24'd0, ep});
    chk({tag, " rd_dir"}, {24'd0, m_rddir}, {24'd0, ed});
  endtask

  initial begin
    logic [7:0] rdy_seq, rv_seq;
    logic [7:0] p_first, p_second;
    int n_rsp, n_late;

    //          id    dir    rdata  lat ren addr   pos    dir_o  blk   err
    vec[0]  = '{2'd0, 8'h07, 8'h00, 3, 2, 8'h01, 8'h01, 8'h07, 1'b0, 1'b0};
    vec[1]  = '{2'd0, 8'h03, 8'h00, 3, 2, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0};
    vec[2]  = '{2'd0, 8'h00, 8'h00, 2, 0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vec[3]  = '{2'd1, 8'h03, 8'h01, 3, 2, 8'hFE, 8'hFF, 8'h03, 1'b1, 1'b0};
    vec[4]  = '{2'd2, 8'h05, 8'h00, 2, 0, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1};
    vec[5]  = '{2'd1, 8'h07, 8'h00, 2, 0, 8'h00, 8'hFF, 8'h07, 1'b1, 1'b0};
    vec[6]  = '{2'd3, 8'h01, 8'h00, 2, 0, 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vec[7]  = '{2'd2, 8'h01, 8'h00, 3, 2, 8'h10, 8'h10, 8'h01, 1'b0, 1'b0};
    vec[8]  = '{2'd1, 8'h00, 8'h00, 3, 2, 8'hEF, 8'hEF, 8'h00, 1'b0, 1'b0};
    vec[9]  = '{2'd3, 8'h00, 8'h02, 3, 2, 8'hEF, 8'hFF, 8'h00, 1'b1, 1'b0};
    vec[10] = '{2'd0, 8'hFF, 8'h00, 2, 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};

    reset = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0;
    req_id = 2'd0; req_dir = 8'h00; wall_rdata = 8'h00; rd_id = 2'd1;
    repeat (3) @(negedge clk);
    chk("reset ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset wall_ren", {31'd0, wall_ren}, 32'd0);
    chk("reset rd_pos", {24'd0, rd_pos}, 32'd0);
    chk("reset rd_dir", {24'd0, rd_dir}, 32'd0);
    reset = 1'b1;
    readback(2'd1, 8'hFF, 8'h00, "init id1");
    readback(2'd2, 8'h00, 8'h01, "init id2");

    for (int i = 0; i < 11; i++) begin
      run_req(vec[i], $sformatf("vec%0d", i));
      if (i == 3) readback(2'd1, 8'hFF, 8'h03, "after wall id1");
      if (i == 4) readback(2'd2, 8'h00, 8'h01, "after err id2");
    end
    readback(2'd0, 8'h00, 8'h00, "final id0");
    readback(2'd1, 8'hEF, 8'h00, "final id1");
    readback(2'd2, 8'h10, 8'h01, "final id2");
    readback(2'd3, 8'hFF, 8'h00, "final id3");

    // Back-to-back: request held high across two transactions.
    sel = 1'b0;
    rdy_seq = '0; rv_seq = '0; p_first = '0; p_second = '0; n_rsp = 0;
    @(negedge clk);
    req_id = 2'd0; req_dir = 8'h07; wall_rdata = 8'h00; req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      rdy_seq[i] = req_ready;
      rv_seq[i]  = rsp_valid;
      if (rsp_valid) begin
        if (n_rsp == 0) p_first = rsp_pos; else p_second = rsp_pos;
        n_rsp++;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b ready idle", {31'd0, req_ready}, 32'd1);
    chk("b2b ready seq", {24'd0, rdy_seq}, 32'h11);
    chk("b2b rsp seq", {24'd0, rv_seq}, 32'h88);
    chk("b2b first pos", {24'd0, p_first}, 32'h01);
    chk("b2b second pos", {24'd0, p_second}, 32'h02);
    repeat (3) @(negedge clk);
    chk("b2b no extra rsp", {31'd0, rsp_valid}, 32'd0);

    // RAM_LAT = 3 instance.
    sel = 1'b1;
    run_req('{2'd0, 8'h07, 8'h00, 5, 2, 8'h01, 8'h01, 8'h07, 1'b0, 1'b0}, "lat3");
    run_req('{2'd1, 8'h00, 8'h01, 5, 2, 8'hEF, 8'hFF, 8'h00, 1'b1, 1'b0}, "lat3 wall");

    // Reset during WAIT on the RAM_LAT = 3 instance.
    @(negedge clk);
    req_id = 2'd1; req_dir = 8'h03; wall_rdata = 8'h00; req_valid3 = 1'b1;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst-wait in WAIT", {31'd0, wall_ren3}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst-wait rsp", {31'd0, rsp_valid3}, 32'd0);
    chk("rst-wait ready", {31'd0, req_ready3}, 32'd1);
    reset = 1'b1;
    n_late = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid3 || rsp_valid) n_late++;
    end
    chk("rst-wait no late rsp", n_late, 0);
    readback(2'd0, 8'h00, 8'h01, "rst dut3 id0");
    readback(2'd1, 8'hFF, 8'h00, "rst dut3 id1");
    sel = 1'b0;
    readback(2'd0, 8'h00, 8'h01, "rst dut id0");
    readback(2'd3, 8'hFF, 8'h00, "rst dut id3");

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/entity_mover.md
# entity_mover

Parametrised successor to the two-tank position/direction store. It holds position and direction registers for N_ENT game entities (tanks and projectiles) on a 2^COL_BITS × 2^ROW_BITS grid and applies movement requests through a valid/ready handshake. Before it commits a move, it looks up the target cell in the board-state RAM so that walls block movement. It sits between the game-control FSM and the board RAM/VGA renderer.

## Interface
- COL_BITS, 4, column field width
- ROW_BITS, 4, row field width; POS_W = ROW_BITS+COL_BITS
- N_ENT, 4, number of entities; ID_W = max(1, clog2(N_ENT))
- RAM_LAT, 1, board RAM read latency in cycles (≥1)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  move request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_id  in  ID_W  entity index
- req_dir  in  8  direction: up 8'h00, down 8'h01, left 8'h03, right 8'h07
- wall_ren  out  1  board RAM read enable
- wall_addr  out  POS_W  board RAM read address
- wall_rdata  in  8  board cell: 8'h00 empty, 8'h01 indestructible wall
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  ID_W  entity the response belongs to
- rsp_pos  out  POS_W  position after the move
- rsp_dir  out  8  direction after the move
- rsp_blocked  out  1  move refused because of a grid edge or a wall
- rsp_err  out  1  req_dir was not one of the four legal codes
- rd_id  in  ID_W  readback select
- rd_pos, rd_dir  out  POS_W, 8  registered readback of the selected entity's current state

## Operation
- Position encoding is {row, col}.
  - Up: row−1. Down: row+1. Left: col−1. Right: col+1.
  - There is no wrap-around. A move off the edge is blocked.
- Reset values:
  - Even ids: pos 0, dir 8'h01.
  - Odd ids: pos all-ones, dir 8'h00.
  - All outputs: 0, except req_ready = 1.
  - State: IDLE.
- FSM states: IDLE, CALC, WAIT, COMMIT.
  - IDLE: when req_valid && req_ready, latch id and dir, then go to CALC.
  - CALC: compute the candidate from the current position and the latched dir.
    - Illegal dir: set err and go to COMMIT.
    - Edge: candidate = current position, set blocked, go to COMMIT.
    - Otherwise: go to WAIT and register wall_ren = 1 and wall_addr = candidate.
  - WAIT: wall_ren is high for the first cycle only. The block counts RAM_LAT cycles, then samples wall_rdata. Any value other than 8'h00 blocks the move. Then go to COMMIT.
  - COMMIT: rsp_valid = 1 for exactly one cycle. At the end of this cycle the registers update, then the FSM returns to IDLE.
    - Legal dir: direction register ← req_dir (this happens even when the move is blocked).
    - Not blocked and legal: position ← candidate.
    - Error: neither register changes; rsp_pos and rsp_dir show the unchanged values.
- Only one request is in flight at a time. A request presented while busy is held by the requester until req_ready goes high.
- Readback: rd_pos and rd_dir register the selected entity's state every cycle. A readback of an entity being committed shows the new value one cycle after COMMIT.
- Out-of-range req_id (≥ N_ENT): treated as an error. rsp_err = 1 and nothing is written.

## Timing
- Accept edge E0. CALC occupies the following cycle C1.
- Error or edge case: rsp_valid is high in C2, giving 2-cycle latency.
- Lookup case:
  - wall_ren is high in C2.
  - wall_rdata is sampled at the end of C(1+RAM_LAT).
  - rsp_valid is high in C(2+RAM_LAT). With the default RAM_LAT = 1 this is C3.
- req_ready goes high again in the cycle after COMMIT. The earliest next accept is at the edge ending that cycle.
- Reset low on any edge:
  - Aborts any operation in flight; no rsp_valid is issued.
  - Restores every register to its reset value.
  - Reset takes priority over a simultaneous commit.

## Test plan
- After reset, id 0 right, wall_rdata = 8'h00 → wall_ren in C2 with wall_addr = 8'h01; rsp_valid in C3 with pos = 8'h01, dir = 8'h07, blocked = 0.
- id 0 up at pos 8'h00 → no wall_ren; rsp_valid in C2 with pos = 8'h00, dir = 8'h00, blocked = 1.
- id 1 left from 8'hFF, wall_rdata = 8'h01 → wall_addr = 8'hFE; response pos = 8'hFF, dir = 8'h03, blocked = 1; rd_id = 1 afterwards reads pos 8'hFF, dir 8'h03.
- req_dir = 8'h05 on id 2 → rsp_err = 1 in C2; rd readback of id 2 is unchanged (pos 8'h00, dir 8'h01).
- Back-to-back requests with req_valid held high → req_ready is low for C1..COMMIT; the second request is accepted only after COMMIT and each gets exactly one rsp_valid. Repeat with RAM_LAT = 3: rsp_valid lands in C5.
- Reset asserted during WAIT → no rsp_valid; all entities return to their reset positions and directions; req_ready is 1 on the next cycle.
